// File: rtl/run_ctrl_pkg.sv
// Shared types and default constants for the run sequencer.
package run_ctrl_pkg;

    // Sequencer states; TIMEOUT is only reachable in the watchdog build.
    typedef enum logic [2:0] {
        StIdle,
        StReset,
        StRun,
        StDone,
        StTimeout
    } state_e;

    localparam int unsigned DefRstCyc = 2;
    localparam int unsigned DefCntW   = 16;
    localparam int unsigned DefMaxCyc = 4095;

endpackage

// File: rtl/sat_counter.sv
// Up-counter with synchronous clear that sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] value
);

    logic [WIDTH-1:0] count_q;

    // Count register: reset/clear win, then saturating increment.
    always_ff @(posedge clock) begin
        if (reset || clear) begin
            count_q <= '0;
        end else if (enable && (count_q != {WIDTH{1'b1}})) begin
            count_q <= count_q + 1'b1;
        end
    end

    assign value = count_q;

endmodule

// File: rtl/run_ctrl.sv
// Run sequencer: turns a host go request into the core start protocol, holds the
// core for RST_CYC cycles, times the run and reports how it ended.
// Define RUN_CTRL_WATCHDOG_EN to compile in the MAX_CYC watchdog and TIMEOUT state.
module run_ctrl
    import run_ctrl_pkg::*;
#(
    parameter int unsigned RST_CYC = DefRstCyc,
    parameter int unsigned CNT_W   = DefCntW,
    parameter int unsigned MAX_CYC = DefMaxCyc
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             go,
    input  logic             core_done,
    output logic             core_start,
    output logic             busy,
    output logic             finished,
    output logic             timeout,
    output logic [CNT_W-1:0] cycle_count
);

    // Phase counter holds RST_CYC-1 down to 0, so clog2(RST_CYC) bits suffice.
    localparam int unsigned PhW = (RST_CYC > 1) ? $clog2(RST_CYC) : 1;
    localparam logic [PhW-1:0] PhLoad = PhW'(RST_CYC - 1);

    state_e         state_q, state_d;
    logic [PhW-1:0] phase_q, phase_d;
    logic           finished_q, finished_d;
    logic           core_start_q, busy_q;
    logic           cnt_clear, cnt_en;

`ifdef RUN_CTRL_WATCHDOG_EN
    localparam logic [CNT_W-1:0] MaxCnt = CNT_W'(MAX_CYC);
    logic timeout_q, timeout_d;
`endif

    // Next-state, phase and status updates.
    always_comb begin
        state_d    = state_q;
        phase_d    = phase_q;
        finished_d = finished_q;
`ifdef RUN_CTRL_WATCHDOG_EN
        timeout_d  = timeout_q;
`endif
        cnt_clear  = 1'b0;
        cnt_en     = 1'b0;
        case (state_q)
            StIdle: begin
                if (go) begin
                    state_d    = StReset;
                    phase_d    = PhLoad;
                    finished_d = 1'b0;
`ifdef RUN_CTRL_WATCHDOG_EN
                    timeout_d  = 1'b0;
`endif
                    cnt_clear  = 1'b1;
                end
            end
            StReset: begin
                // core_done is stale here and deliberately ignored.
                if (phase_q == '0) begin
                    state_d = StRun;
                end else begin
                    phase_d = phase_q - 1'b1;
                end
            end
            StRun: begin
                if (core_done) begin
                    state_d    = StDone;
                    finished_d = 1'b1;
`ifdef RUN_CTRL_WATCHDOG_EN
                end else if (cycle_count == MaxCnt) begin
                    state_d   = StTimeout;
                    timeout_d = 1'b1;
`endif
                end else begin
                    cnt_en = 1'b1;
                end
            end
            StDone, StTimeout: begin
                // go must drop before another run can start.
                if (!go) begin
                    state_d = StIdle;
                end
            end
            default: begin
                state_d = StIdle;
            end
        endcase
    end

    // State and status registers; outputs are registered from the next state.
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q      <= StIdle;
            phase_q      <= '0;
            finished_q   <= 1'b0;
            core_start_q <= 1'b1;
            busy_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            phase_q      <= phase_d;
            finished_q   <= finished_d;
            core_start_q <= (state_d != StRun);
            busy_q       <= (state_d == StReset) || (state_d == StRun);
        end
    end

`ifdef RUN_CTRL_WATCHDOG_EN
    // Sticky watchdog flag.
    always_ff @(posedge clock) begin
        if (reset) begin
            timeout_q <= 1'b0;
        end else begin
            timeout_q <= timeout_d;
        end
    end

    assign timeout = timeout_q;
`else
    assign timeout = 1'b0;
`endif

    sat_counter #(
        .WIDTH (CNT_W)
    ) u_cycle_cnt (
        .clock  (clock),
        .reset  (reset),
        .clear  (cnt_clear),
        .enable (cnt_en),
        .value  (cycle_count)
    );

    assign core_start = core_start_q;
    assign busy       = busy_q;
    assign finished   = finished_q;

endmodule
